// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared state encoding, default widths and requantizer for the psum drain path
package psum_pkg;

    localparam int DEF_COL            = 8;
    localparam int DEF_OUT_DATA_WIDTH = 32;
    localparam int DEF_IN_DATA_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH     = 7;
    localparam int FIFO_DEPTH         = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

    // Divide by 2^shift with round-half-to-even, then clamp to the signed 8-bit range.
    function automatic logic [DEF_IN_DATA_WIDTH-1:0] quant_rhe(
        input logic [DEF_OUT_DATA_WIDTH-1:0] p,
        input int                            shift
    );
        logic signed [DEF_OUT_DATA_WIDTH-1:0] q;
        logic        [DEF_OUT_DATA_WIDTH-1:0] one;
        logic        [DEF_OUT_DATA_WIDTH-1:0] mask;
        logic g;
        logic s;
        logic l;
        one  = DEF_OUT_DATA_WIDTH'(1);
        q    = $signed(p) >>> shift;
        mask = (one << (shift - 1)) - one;
        g    = (p & (one << (shift - 1))) != '0;
        l    = (p & (one << shift)) != '0;
        s    = (p & mask) != '0;
        if (g && (s || l)) begin
            q = q + 1;
        end
        if (q > 127) begin
            return 8'h7f;
        end
        if (q < -128) begin
            return 8'h80;
        end
        return q[DEF_IN_DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/psum_row_fifo.sv
// rtl/psum_row_fifo.sv - 4-entry synchronous row FIFO (packed row plus last flag) with occupancy count
module psum_row_fifo
    import psum_pkg::*;
#(
    parameter int WIDTH = DEF_COL * DEF_IN_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [2:0]       count
);

    // Two-bit pointers wrap naturally over the fixed four entries.
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/psum_quant_drain.sv
// rtl/psum_quant_drain.sv - drains the finished psum buffer, requantizes each row and streams packed rows out
module psum_quant_drain
    import psum_pkg::*;
#(
    parameter int COL            = DEF_COL,
    parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
    parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int SHIFT          = 11,
    parameter int RD_LAT         = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic [ADDR_WIDTH:0]           num_rows,
    output logic                          busy,
    output logic                          done,
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic [COL*OUT_DATA_WIDTH-1:0] rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COL*IN_DATA_WIDTH-1:0]  out_data,
    output logic                          out_last
);

    localparam int ROW_W = COL * IN_DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    drain_state_t state;
    drain_state_t state_nx;

    logic [ADDR_WIDTH:0] num_rows_q;
    logic [ADDR_WIDTH:0] rd_cnt;
    logic [ADDR_WIDTH:0] out_cnt;
    logic [ADDR_WIDTH:0] last_idx;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [RD_LAT-1:0]   last_pipe;
    logic [2:0]          inflight;
    logic [2:0]          fifo_count;
    logic [3:0]          credit_used;
    logic                issue;
    logic                issue_last;
    logic                pop;
    logic [ROW_W-1:0]    q_row;
    logic [ROW_W:0]      head;

    assign last_idx   = num_rows_q - CNT_ONE;
    assign issue_last = (rd_cnt == last_idx);
    assign pop        = out_valid & out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {2'b00, vld_pipe[i]};
        end
    end

    // Rows in flight plus rows parked in the FIFO never exceed its depth, so pushes always fit.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign issue       = (state == ST_ISSUE) && (credit_used < 4'(FIFO_DEPTH));

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (num_rows == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue && issue_last) begin
                    state_nx = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (pop && (out_cnt == last_idx)) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state      <= ST_IDLE;
            num_rows_q <= '0;
            rd_cnt     <= '0;
            out_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE) begin
                if (start) begin
                    num_rows_q <= num_rows;
                    rd_cnt     <= '0;
                    out_cnt    <= '0;
                end
            end else begin
                if (issue) begin
                    rd_cnt <= rd_cnt + CNT_ONE;
                end
                if (pop) begin
                    out_cnt <= out_cnt + CNT_ONE;
                end
            end
        end
    end

    // The last flag rides alongside the read so it lands in the FIFO with its row.
    always_ff @(posedge clk) begin
        if (rstn) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= issue;
            last_pipe[0] <= issue & issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    for (genvar i = 0; i < COL; i++) begin : g_lane
        assign q_row[i*IN_DATA_WIDTH +: IN_DATA_WIDTH] =
            quant_rhe(rd_data[i*OUT_DATA_WIDTH +: OUT_DATA_WIDTH], SHIFT);
    end

    psum_row_fifo #(
        .WIDTH (ROW_W + 1)
    ) u_row_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (vld_pipe[RD_LAT-1]),
        .push_data ({last_pipe[RD_LAT-1], q_row}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

    assign busy      = (state == ST_ISSUE) || (state == ST_FLUSH);
    assign done      = (state == ST_DONE);
    assign rd_en     = issue;
    assign rd_addr   = issue ? rd_cnt[ADDR_WIDTH-1:0] : '0;
    assign out_valid = (fifo_count != 3'd0);
    assign out_data  = head[ROW_W-1:0];
    assign out_last  = head[ROW_W];

endmodule

// File: tb/tb_psum_quant_drain.sv
// tb/tb_psum_quant_drain.sv - directed bench driving RD_LAT=1 and RD_LAT=2 drains side by side
module tb_psum_quant_drain;

    localparam int AW = 7;
    localparam int NV = 13;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic             out_ready;
    logic [AW:0]      num_rows;
    logic             busy [2];
    logic             done [2];
    logic             rd_en [2];
    logic [AW-1:0]    rd_addr [2];
    logic [255:0]     rd_data [2];
    logic             out_valid [2];
    logic [63:0]      out_data [2];
    logic             out_last [2];
    logic [255:0]     stage1;
    logic [255:0]     pmem [128];

    logic [31:0] vec_p [NV] = '{32'h00000C00, 32'h00000400, 32'h00000401, 32'h00001400,
                                32'hFFFFF800, 32'h0007FFFF, 32'hFFF00000, 32'hFFFFFC00,
                                32'hFFFFF400, 32'h0003F800, 32'h00040000, 32'hFFFC0000,
                                32'h00000BFF};
    logic [7:0]  vec_q [NV] = '{8'h02, 8'h00, 8'h01, 8'h02, 8'hFF, 8'h7F, 8'h80, 8'h00,
                                8'hFE, 8'h7F, 8'h7F, 8'h80, 8'h01};

    int n_tests;
    int n_fail;
    int cyc = 0;
    int s0;
    bit clr_req;

    logic [64:0] got_row  [2][256];
    int          hs_cyc   [2][256];
    int          addr_log [2][256];
    int          addr_cyc [2][256];
    int          got_cnt [2];
    int          rd_seen [2];
    int          done_cnt [2];
    int          done_cyc [2];
    int          stab_err [2];
    int          max_out [2];
    logic        prev_stall [2];
    logic [64:0] prev_row [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psum_quant_drain #(.RD_LAT(1)) dut_l1 (
        .clk(clk), .rstn(rstn), .start(start), .num_rows(num_rows),
        .busy(busy[0]), .done(done[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .out_last(out_last[0])
    );

    psum_quant_drain #(.RD_LAT(2)) dut_l2 (
        .clk(clk), .rstn(rstn), .start(start), .num_rows(num_rows),
        .busy(busy[1]), .done(done[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .out_last(out_last[1])
    );

    // Buffer models: un-enabled reads return a poison pattern so mistimed captures show up.
    always @(posedge clk) begin
        rd_data[0] <= rd_en[0] ? pmem[rd_addr[0]] : {8{32'hDEADBEEF}};
        stage1     <= rd_en[1] ? pmem[rd_addr[1]] : {8{32'hDEADBEEF}};
        rd_data[1] <= stage1;
    end

    always @(negedge clk) begin
        logic [64:0] row;
        if (clr_req) begin
            for (int k = 0; k < 2; k++) begin
                got_cnt[k] = 0; rd_seen[k] = 0; done_cnt[k] = 0; done_cyc[k] = 0;
                stab_err[k] = 0; max_out[k] = 0; prev_stall[k] = 1'b0;
            end
        end else if (rstn) begin
            for (int k = 0; k < 2; k++) prev_stall[k] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                row = {out_last[k], out_data[k]};
                if (prev_stall[k] && (!out_valid[k] || row !== prev_row[k])) stab_err[k]++;
                if (rd_en[k]) begin
                    if (rd_seen[k] < 256) begin
                        addr_log[k][rd_seen[k]] = int'(rd_addr[k]);
                        addr_cyc[k][rd_seen[k]] = cyc;
                    end
                    rd_seen[k]++;
                end
                if (rd_seen[k] - got_cnt[k] > max_out[k]) max_out[k] = rd_seen[k] - got_cnt[k];
                if (out_valid[k] && out_ready) begin
                    if (got_cnt[k] < 256) begin
                        got_row[k][got_cnt[k]] = row;
                        hs_cyc[k][got_cnt[k]]  = cyc;
                    end
                    got_cnt[k]++;
                end
                if (done[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc;
                end
                prev_stall[k] = out_valid[k] && !out_ready;
                prev_row[k]   = row;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_row(input int a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = vec_q[(a*3 + i) % NV];
        return r;
    endfunction

    task automatic chk_idle(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_ctl_l%0d", tag, k+1),
                  65'({busy[k], done[k], rd_en[k], rd_addr[k], out_valid[k], out_last[k]}), 65'(0));
            check($sformatf("%s_data_l%0d", tag, k+1), 65'(out_data[k]), 65'(0));
        end
    endtask

    task automatic clear_logs();
        clr_req = 1'b1;
        tick();
        tick();
        clr_req = 1'b0;
    endtask

    task automatic do_start(input int n);
        num_rows = AW'(n) == 0 && n != 0 ? (AW+1)'(n) : (AW+1)'(n);
        start    = 1'b1;
        s0       = cyc;
        tick();
        start    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("busy_c1_l%0d", k+1), 65'(busy[k]), 65'(n > 0));
            check($sformatf("done_c1_l%0d", k+1), 65'(done[k]), 65'(n == 0));
        end
    endtask

    task automatic wait_done(input bit bp, input int budget);
        int i;
        i = 0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && i < budget) begin
            out_ready = bp ? (i % 3 == 0) : 1'b1;
            tick();
            i++;
        end
        check("done_within_budget", 65'(i < budget), 65'(1));
        out_ready = 1'b1;
    endtask

    task automatic verify(input int n, input bit timing);
        for (int k = 0; k < 2; k++) begin
            int lat;
            lat = k + 1;
            check($sformatf("row_count_l%0d", lat), 65'(got_cnt[k]), 65'(n));
            check($sformatf("rd_count_l%0d", lat), 65'(rd_seen[k]), 65'(n));
            check($sformatf("done_count_l%0d", lat), 65'(done_cnt[k]), 65'(1));
            check($sformatf("stall_stable_l%0d", lat), 65'(stab_err[k]), 65'(0));
            for (int j = 0; j < n && j < 256; j++) begin
                logic lastb;
                lastb = (j == n - 1);
                if (j < rd_seen[k]) check($sformatf("addr_l%0d_%0d", lat, j), 65'(addr_log[k][j]), 65'(j));
                if (j < got_cnt[k]) check($sformatf("row_l%0d_%0d", lat, j), got_row[k][j], {lastb, exp_row(j)});
                if (timing && j < rd_seen[k])
                    check($sformatf("addr_cyc_l%0d_%0d", lat, j), 65'(addr_cyc[k][j]), 65'(s0 + 1 + j));
                if (timing && j < got_cnt[k])
                    check($sformatf("hs_cyc_l%0d_%0d", lat, j), 65'(hs_cyc[k][j]), 65'(s0 + 2 + lat + j));
            end
            if (got_cnt[k] > 0 && got_cnt[k] <= 256)
                check($sformatf("done_cyc_l%0d", lat), 65'(done_cyc[k]), 65'(hs_cyc[k][got_cnt[k]-1] + 1));
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0; clr_req = 1'b0;
        rstn = 1'b1; start = 1'b0; out_ready = 1'b1; num_rows = '0;
        for (int a = 0; a < 128; a++)
            for (int i = 0; i < 8; i++) pmem[a][i*32 +: 32] = vec_p[(a*3 + i) % NV];
        repeat (3) tick();
        rstn = 1'b0;
        chk_idle("reset");
        tick();

        clear_logs();
        out_ready = 1'b1;
        do_start(8);
        wait_done(1'b0, 200);
        verify(8, 1'b1);

        clear_logs();
        out_ready = 1'b0;
        do_start(16);
        wait_done(1'b1, 400);
        verify(16, 1'b0);
        for (int k = 0; k < 2; k++) check($sformatf("credit_peak_l%0d", k+1), 65'(max_out[k]), 65'(4));

        clear_logs();
        do_start(0);
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("zero_rd_l%0d", k+1), 65'(rd_seen[k]), 65'(0));
            check($sformatf("zero_done_cnt_l%0d", k+1), 65'(done_cnt[k]), 65'(1));
            check($sformatf("zero_done_cyc_l%0d", k+1), 65'(done_cyc[k]), 65'(s0 + 1));
        end

        clear_logs();
        out_ready = 1'b1;
        do_start(128);
        wait_done(1'b0, 400);
        verify(128, 1'b1);

        clear_logs();
        do_start(8);
        repeat (2) tick();
        num_rows = 8'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(1'b0, 200);
        repeat (6) tick();
        verify(8, 1'b0);

        clear_logs();
        out_ready = 1'b0;
        do_start(16);
        repeat (5) tick();
        rstn = 1'b1;
        tick();
        chk_idle("midreset");
        rstn = 1'b0;
        repeat (10) tick();
        for (int k = 0; k < 2; k++) check($sformatf("midreset_no_done_l%0d", k+1), 65'(done_cnt[k]), 65'(0));

        clear_logs();
        out_ready = 1'b1;
        do_start(4);
        wait_done(1'b0, 100);
        verify(4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
